// File: rtl/decoder_n_scan.sv
// One-hot line decoder with an auto-scan mode that steps through all lines, holding each for DWELL cycles.
// Define DECODER_N_SCAN_ACTIVE_LOW_EN to make d_o active-low (active line 0, blank/reset value all ones).
module decoder_n_scan #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        a_i,
    output logic [(2**SEL_W)-1:0]   d_o,
    output logic [SEL_W-1:0]        idx_o,
    output logic                    valid_o,
    output logic                    wrap_o
);

    localparam int N = 2**SEL_W;
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
`ifdef DECODER_N_SCAN_ACTIVE_LOW_EN
    localparam logic [N-1:0] BLANK = {N{1'b1}};
`else
    localparam logic [N-1:0] BLANK = '0;
`endif

    function automatic logic [N-1:0] line_of(input logic [SEL_W-1:0] sel);
        logic [N-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
`ifdef DECODER_N_SCAN_ACTIVE_LOW_EN
        return ~oh;
`else
        return oh;
`endif
    endfunction

    logic [N-1:0]     r_d;
    logic [SEL_W-1:0] r_idx;
    logic             r_valid;
    logic             r_wrap;
    logic [SEL_W-1:0] r_scan_idx;
    logic [15:0]      r_dwell_cnt;
    logic             r_wrap_pend;
    logic             r_mode_q;

    logic [N-1:0]     w_d_nxt;
    logic [SEL_W-1:0] w_idx_nxt;
    logic             w_valid_nxt;
    logic             w_wrap_nxt;
    logic [SEL_W-1:0] w_scan_idx_nxt;
    logic [15:0]      w_dwell_nxt;
    logic             w_pend_nxt;
    logic             w_mode_nxt;

    // A 0->1 mode edge overrides the stored scan state so line 0 starts a fresh dwell.
    logic             w_restart;
    logic [SEL_W-1:0] w_eff_idx;
    logic [15:0]      w_eff_cnt;
    logic             w_pend_eff;
    logic             w_terminal;

    assign w_restart  = mode_i & ~r_mode_q;
    assign w_eff_idx  = w_restart ? '0 : r_scan_idx;
    assign w_eff_cnt  = w_restart ? '0 : r_dwell_cnt;
    assign w_pend_eff = w_restart ? 1'b0 : r_wrap_pend;
    assign w_terminal = (w_eff_cnt == DWELL_LAST);

    always_comb begin
        w_d_nxt        = BLANK;
        w_idx_nxt      = r_idx;
        w_valid_nxt    = en_i;
        w_wrap_nxt     = 1'b0;
        w_scan_idx_nxt = r_scan_idx;
        w_dwell_nxt    = r_dwell_cnt;
        w_pend_nxt     = r_wrap_pend;
        w_mode_nxt     = r_mode_q;
        if (en_i) begin
            w_mode_nxt = mode_i;
            if (!mode_i) begin
                w_d_nxt        = line_of(a_i);
                w_idx_nxt      = a_i;
                w_scan_idx_nxt = '0;
                w_dwell_nxt    = '0;
                w_pend_nxt     = 1'b0;
            end else begin
                w_d_nxt    = line_of(w_eff_idx);
                w_idx_nxt  = w_eff_idx;
                w_wrap_nxt = w_pend_eff;
                // Pending flag marks that the next line-0 display follows a real N-1 -> 0 wrap.
                w_pend_nxt = w_terminal & (&w_eff_idx);
                if (w_terminal) begin
                    w_dwell_nxt    = '0;
                    w_scan_idx_nxt = w_eff_idx + SEL_W'(1);
                end else begin
                    w_dwell_nxt    = w_eff_cnt + 16'd1;
                    w_scan_idx_nxt = w_eff_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_d         <= BLANK;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_scan_idx  <= '0;
            r_dwell_cnt <= '0;
            r_wrap_pend <= 1'b0;
            r_mode_q    <= 1'b0;
        end else begin
            r_d         <= w_d_nxt;
            r_idx       <= w_idx_nxt;
            r_valid     <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
            r_scan_idx  <= w_scan_idx_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_wrap_pend <= w_pend_nxt;
            r_mode_q    <= w_mode_nxt;
        end
    end

    assign d_o     = r_d;
    assign idx_o   = r_idx;
    assign valid_o = r_valid;
    assign wrap_o  = r_wrap;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Scoreboard bench for decoder_n_scan: two instances (DWELL=3 and DWELL=4) share the same inputs.
// Expected responses are packed as {d, idx, valid, wrap}; each vector names which instance it checks.
module tb_decoder_n_scan;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       en;
    logic       mode;
    logic [1:0] a;

    logic [3:0] d3_d, d4_d;
    logic [1:0] d3_idx, d4_idx;
    logic       d3_valid, d4_valid;
    logic       d3_wrap, d4_wrap;

    int n_checks = 0;
    int n_pass   = 0;
    int s3       = 0;
    int s4       = 0;

    logic [7:0] exp3_q[$];
    logic [7:0] exp4_q[$];

    // Line order seen by the DWELL=3 instance after entering scan mode.
    int scan3[19] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 1, 1, 2};

    always #5 clk = ~clk;

    decoder_n_scan #(.SEL_W(2), .DWELL(3)) u_d3 (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .en_i    (en),
        .mode_i  (mode),
        .a_i     (a),
        .d_o     (d3_d),
        .idx_o   (d3_idx),
        .valid_o (d3_valid),
        .wrap_o  (d3_wrap)
    );

    decoder_n_scan #(.SEL_W(2), .DWELL(4)) u_d4 (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .en_i    (en),
        .mode_i  (mode),
        .a_i     (a),
        .d_o     (d4_d),
        .idx_o   (d4_idx),
        .valid_o (d4_valid),
        .wrap_o  (d4_wrap)
    );

    function automatic logic [3:0] pol(input logic [3:0] d);
`ifdef DECODER_N_SCAN_ACTIVE_LOW_EN
        return ~d;
`else
        return d;
`endif
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001;
        return v << i;
    endfunction

    task automatic check(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got d=%b idx=%0d valid=%b wrap=%b, expected d=%b idx=%0d valid=%b wrap=%b",
                     name, step, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // sel[0] checks the DWELL=3 instance, sel[1] the DWELL=4 instance.
    task automatic drive(input logic [1:0] sel, input logic i_en, input logic i_mode, input logic [1:0] i_a,
                         input logic [3:0] e_d, input logic [1:0] e_idx, input logic e_v, input logic e_w);
        en   = i_en;
        mode = i_mode;
        a    = i_a;
        if (sel[0]) exp3_q.push_back({pol(e_d), e_idx, e_v, e_w});
        if (sel[1]) exp4_q.push_back({pol(e_d), e_idx, e_v, e_w});
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp3_q.size() != 0) begin
            s3++;
            check("dwell3", s3, {d3_d, d3_idx, d3_valid, d3_wrap}, exp3_q.pop_front());
        end
        if (exp4_q.size() != 0) begin
            s4++;
            check("dwell4", s4, {d4_d, d4_idx, d4_valid, d4_wrap}, exp4_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        a      = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset3", 0, {d3_d, d3_idx, d3_valid, d3_wrap}, {pol(4'b0000), 2'd0, 1'b0, 1'b0});
        check("reset4", 0, {d4_d, d4_idx, d4_valid, d4_wrap}, {pol(4'b0000), 2'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst_ni = 1'b1;

        // Decode sweep on both instances.
        drive(2'b11, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b1, 1'b0);

        // Scan with DWELL=3: wrap pulse exactly at cycle 13, continue to line 2.
        for (int c = 1; c <= 19; c++)
            drive(2'b01, 1'b1, 1'b1, 2'd0, oh(scan3[c-1]), 2'(scan3[c-1]), 1'b1, c == 13);

        // Mode switch to decode, then back to scan: restart at line 0 without a wrap pulse.
        drive(2'b01, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd3, 4'b0001, 2'd0, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd3, 4'b0001, 2'd0, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd3, 4'b0001, 2'd0, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd3, 4'b0010, 2'd1, 1'b1, 1'b0);

        // Enable pause with DWELL=4, mid-dwell on line 2.
        drive(2'b11, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 1; c <= 10; c++)
            drive(2'b10, 1'b1, 1'b1, 2'd0, oh((c - 1) / 4), 2'((c - 1) / 4), 1'b1, 1'b0);
        for (int c = 0; c < 5; c++)
            drive(2'b10, 1'b0, 1'b1, 2'd0, 4'b0000, 2'd2, 1'b0, 1'b0);
        drive(2'b10, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0);
        drive(2'b10, 1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++)
            drive(2'b10, 1'b1, 1'b1, 2'd0, 4'b1000, 2'd3, 1'b1, 1'b0);
        drive(2'b10, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b1);

        // Reset mid-scan at line 3, second dwell cycle, between clock edges.
        drive(2'b01, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 1; c <= 11; c++)
            drive(2'b01, 1'b1, 1'b1, 2'd0, oh(scan3[c-1]), 2'(scan3[c-1]), 1'b1, 1'b0);
        #1 rst_ni = 1'b0;
        #1;
        check("async_rst3", 0, {d3_d, d3_idx, d3_valid, d3_wrap}, {pol(4'b0000), 2'd0, 1'b0, 1'b0});
        check("async_rst4", 0, {d4_d, d4_idx, d4_valid, d4_wrap}, {pol(4'b0000), 2'd0, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        drive(2'b01, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp3_q.size() + exp4_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected responses left, required 0", exp3_q.size() + exp4_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_n_scan.md
DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 2: select width; legal range 1..6; outputs are N = 2**SEL_W lines.
REQ-002 SHALL have parameter DWELL, default 4: cycles each line is held in scan mode; legal range 1..65535.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en_i, input, 1 bit: enable; when low, outputs are blanked and counters hold.
REQ-006 SHALL have port mode_i, input, 1 bit: 0 = decode a_i; 1 = auto-scan.
REQ-007 SHALL have port a_i, input, SEL_W bits: select index in decode mode; ignored in scan mode.
REQ-008 SHALL have port d_o, output, N bits: registered one-hot line outputs.
REQ-009 SHALL have port idx_o, output, SEL_W bits: registered index of the line currently driven.
REQ-010 SHALL have port valid_o, output, 1 bit: high when d_o drives exactly one active line.
REQ-011 SHALL have port wrap_o, output, 1 bit: one-cycle pulse when the scan index wraps from N-1 to 0.

Function
REQ-012 SHALL register all outputs; no combinational path from any input to any output.
REQ-013 Decode mode (en_i=1, mode_i=0) SHALL set d_o to one-hot(a_i) and idx_o to a_i one cycle after sampling; latency is 1 cycle.
REQ-014 In scan mode (en_i=1, mode_i=1), a dwell counter SHALL count 0..DWELL-1; on terminal count it SHALL return to 0 and the scan index SHALL increment.
REQ-015 The scan index SHALL wrap from N-1 to 0, and wrap_o SHALL be high in the cycle d_o first shows line 0 after a wrap.
REQ-016 With DWELL=1, the scan index SHALL advance every cycle.
REQ-017 On a mode_i 0->1 transition, the scan index and dwell counter SHALL restart at 0, and line 0 SHALL appear on the following cycle for a full DWELL cycles; that restart SHALL NOT pulse wrap_o.
REQ-018 On a mode_i 1->0 transition, the block SHALL decode a_i on the next cycle; scan state is discarded.
REQ-019 When en_i=0, the next cycle SHALL show all d_o lines inactive and valid_o=0, wrap_o=0, idx_o held.
REQ-020 When en_i=0, the scan index and dwell counter SHALL hold, and scanning SHALL resume from the held state when en_i returns to 1 in scan mode.
REQ-021 valid_o SHALL equal the registered en_i; d_o SHALL never have more than one active line.
REQ-022 When SEL_W=1, the block SHALL degenerate to a 1-to-2 decoder and scanner; the scan index SHALL toggle.

Reset
REQ-023 Asserting rst_ni low SHALL immediately and asynchronously force: d_o all inactive, idx_o=0, valid_o=0, wrap_o=0, scan index=0, dwell counter=0.
REQ-024 Reset asserted mid-dwell or mid-scan SHALL discard all progress; after release, the first enabled scan cycle SHALL show line 0 with a full dwell.
REQ-025 Deassertion SHALL be sampled on clk_i; the first register update SHALL occur on the first rising edge with rst_ni high.

Configuration
REQ-026 Macro DECODER_N_SCAN_ACTIVE_LOW_EN SHALL select the output polarity.
REQ-027 With the macro defined, d_o SHALL be active-low: the active line is 0, inactive lines are 1, and the reset and blanked value is all ones.
REQ-028 Without the macro, d_o SHALL be active-high: the active line is 1, and the reset and blanked value is all zeros.
REQ-029 The macro SHALL NOT affect idx_o, valid_o, wrap_o or any timing.

Verification
REQ-030 Decode sweep: SEL_W=2, en=1, mode=0, a_i=0,1,2,3 on consecutive cycles -> d_o=0001,0010,0100,1000 each 1 cycle later; idx_o matches; valid_o=1.
REQ-031 Scan wrap: SEL_W=2, DWELL=3, mode=1 -> each line held 3 cycles in order 0,1,2,3,0; wrap_o high exactly one cycle, when line 0 reappears (cycle 13 after entry).
REQ-032 Enable pause: scanning with DWELL=4, drop en_i for 5 cycles mid-dwell at line 2 -> d_o=0 and valid_o=0 for 5 cycles; on resume, line 2 completes its remaining dwell.
REQ-033 Reset mid-operation: assert rst_ni at line 3, dwell count 1, without waiting for a clock -> outputs cleared immediately; after release, line 0 shows for a full dwell.
REQ-034 Mode switch: scan at line 2, set mode=0 with a_i=1 -> next cycle d_o=0010; set mode=1 -> line 0 restarts, no wrap_o pulse.
REQ-035 Polarity: rerun the REQ-030 scenario with DECODER_N_SCAN_ACTIVE_LOW_EN defined -> d_o=1110,1101,1011,0111; reset value is 1111.
